// File: rtl/toggle_event_decoder.sv
// Toggle-encoded event receiver: every transition of level_in becomes one event,
// queued in a saturating pending counter and released on a valid/ready handshake.
`timescale 1ns/1ps

module toggle_event_decoder #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        INIT_LEVEL  = 1'b0,
    parameter int unsigned PEND_WIDTH  = 3,
    parameter int unsigned CNT_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  level_in,
    output logic                  evt_valid,
    input  logic                  evt_ready,
    output logic [PEND_WIDTH-1:0] pending,
    output logic [CNT_WIDTH-1:0]  total_events,
    output logic                  overflow,
    input  logic                  clear_ovf,
    output logic                  level
);

    localparam logic [PEND_WIDTH-1:0] FULL = '1;

    logic                  w_level_q;
    logic                  w_edge;
    logic                  w_pop;
    logic                  w_drop;
    logic                  r_prev;
    logic [PEND_WIDTH-1:0] r_pending;
    logic [CNT_WIDTH-1:0]  r_total;
    logic                  r_overflow;

    generate
        if (SYNC_STAGES == 0) begin : g_no_sync
            // Same-clock source: no metastability protection needed.
            assign w_level_q = level_in;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] r_sync;

            // NOTE: sequential state uses non-blocking assignments so every flop
            // samples the pre-edge value of its neighbour, giving a true shift chain.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_sync <= {SYNC_STAGES{INIT_LEVEL}};
                end else begin
                    r_sync[0] <= level_in;
                    for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                        r_sync[i] <= r_sync[i-1];
                    end
                end
            end

            assign w_level_q = r_sync[SYNC_STAGES-1];
        end
    endgenerate

    assign w_edge = w_level_q ^ r_prev;
    assign w_pop  = evt_valid & evt_ready;
    // An event is only lost when it arrives into a full queue with nothing leaving.
    assign w_drop = w_edge & ~w_pop & (r_pending == FULL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev     <= INIT_LEVEL;
            r_pending  <= '0;
            r_total    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_prev <= w_level_q;

            if (w_edge) begin
                r_total <= r_total + 1'b1;
            end

            case ({w_edge, w_pop})
                2'b10: begin
                    if (r_pending != FULL) begin
                        r_pending <= r_pending + 1'b1;
                    end
                end
                2'b01:   r_pending <= r_pending - 1'b1;
                default: ;
            endcase

            // A drop in the same cycle as a clear leaves the flag set.
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (clear_ovf) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign evt_valid    = (r_pending != '0);
    assign pending      = r_pending;
    assign total_events = r_total;
    assign overflow     = r_overflow;
    assign level        = r_prev;

endmodule

// File: tb/tb_toggle_event_decoder.sv
// Scoreboard bench for toggle_event_decoder: one same-clock instance (SYNC_STAGES=0)
// and one synchronized instance (SYNC_STAGES=2) sharing clock and reset.
`timescale 1ns/1ps

module tb_toggle_event_decoder;

    typedef struct {
        string name;
        int    dut;
        int    pend;
        int    valid;
        int    total;
        int    ovf;
        int    lvl;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;

    logic       lvl0 = 1'b0, rdy0 = 1'b0, clr0 = 1'b0;
    logic       v0, o0, l0;
    logic [2:0] p0;
    logic [7:0] t0;

    logic       lvl2 = 1'b0, rdy2 = 1'b0, clr2 = 1'b0;
    logic       v2, o2, l2;
    logic [2:0] p2;
    logic [7:0] t2;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    toggle_event_decoder #(
        .SYNC_STAGES(0), .INIT_LEVEL(1'b0), .PEND_WIDTH(3), .CNT_WIDTH(8)
    ) dut0 (
        .clk(clk), .rst(rst), .level_in(lvl0), .evt_valid(v0), .evt_ready(rdy0),
        .pending(p0), .total_events(t0), .overflow(o0), .clear_ovf(clr0), .level(l0)
    );

    toggle_event_decoder #(
        .SYNC_STAGES(2), .INIT_LEVEL(1'b0), .PEND_WIDTH(3), .CNT_WIDTH(8)
    ) dut2 (
        .clk(clk), .rst(rst), .level_in(lvl2), .evt_valid(v2), .evt_ready(rdy2),
        .pending(p2), .total_events(t2), .overflow(o2), .clear_ovf(clr2), .level(l2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: compares the DUT state against the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            if (e.dut == 0) begin
                check({e.name, ".pending"},   32'(p0), 32'(e.pend));
                check({e.name, ".evt_valid"}, 32'(v0), 32'(e.valid));
                check({e.name, ".total"},     32'(t0), 32'(e.total));
                check({e.name, ".overflow"},  32'(o0), 32'(e.ovf));
                check({e.name, ".level"},     32'(l0), 32'(e.lvl));
            end else begin
                check({e.name, ".pending"},   32'(p2), 32'(e.pend));
                check({e.name, ".evt_valid"}, 32'(v2), 32'(e.valid));
                check({e.name, ".total"},     32'(t2), 32'(e.total));
                check({e.name, ".overflow"},  32'(o2), 32'(e.ovf));
                check({e.name, ".level"},     32'(l2), 32'(e.lvl));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_state(input string name, input int dut, input int pend,
                                input int valid, input int total, input int ovf, input int lvl);
        exp_t e;
        e.name  = name;
        e.dut   = dut;
        e.pend  = pend;
        e.valid = valid;
        e.total = total;
        e.ovf   = ovf;
        e.lvl   = lvl;
        sb.push_back(e);
        @(negedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, ".pending"},   32'(p0), 32'd0);
        check({name, ".evt_valid"}, 32'(v0), 32'd0);
        check({name, ".total"},     32'(t0), 32'd0);
        check({name, ".overflow"},  32'(o0), 32'd0);
        check({name, ".level"},     32'(l0), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset applied before any clock edge: outputs must already be cleared.
        #1 rst = 1'b1;
        #2;
        check_reset_outputs("async_reset_start");
        check("async_reset_start.dut2_pending", 32'(p2), 32'd0);
        @(negedge clk);
        #1 rst = 1'b0;
        tick();
        tick();
        expect_state("hold",      0, 0, 0, 0, 0, 0);
        expect_state("hold_sync", 2, 0, 0, 0, 0, 0);

        // Two-stage synchronizer: event visible only after the third edge.
        lvl2 = 1'b1;
        tick(); expect_state("sync_edge1", 2, 0, 0, 0, 0, 0);
        tick(); expect_state("sync_edge2", 2, 0, 0, 0, 0, 0);
        tick(); expect_state("sync_edge3", 2, 1, 1, 1, 0, 1);

        lvl0 = 1'b1;
        tick(); expect_state("single_event", 0, 1, 1, 1, 0, 1);
        rdy0 = 1'b1;
        tick(); expect_state("single_pop",   0, 0, 0, 1, 0, 1);
        rdy0 = 1'b0;

        for (int i = 0; i < 7; i++) begin
            lvl0 = ~lvl0;
            tick();
        end
        expect_state("fill_to_full", 0, 7, 1, 8, 0, 0);
        for (int i = 0; i < 2; i++) begin
            lvl0 = ~lvl0;
            tick();
        end
        expect_state("saturated_drop", 0, 7, 1, 10, 1, 0);

        clr0 = 1'b1;
        tick(); clr0 = 1'b0;
        expect_state("clear_ovf", 0, 7, 1, 10, 0, 0);

        clr0 = 1'b1; lvl0 = ~lvl0;
        tick(); clr0 = 1'b0;
        expect_state("clear_vs_drop", 0, 7, 1, 11, 1, 1);

        rdy0 = 1'b1; lvl0 = ~lvl0;
        tick(); rdy0 = 1'b0;
        expect_state("full_edge_pop_ovf_set", 0, 7, 1, 12, 1, 0);

        clr0 = 1'b1;
        tick(); clr0 = 1'b0;
        expect_state("clear_ovf_again", 0, 7, 1, 12, 0, 0);

        rdy0 = 1'b1; lvl0 = ~lvl0;
        tick();
        expect_state("full_edge_pop_ovf_clear", 0, 7, 1, 13, 0, 1);
        tick();
        expect_state("pop_no_edge", 0, 6, 1, 13, 0, 1);
        repeat (6) tick();
        expect_state("drained", 0, 0, 0, 13, 0, 1);
        tick();
        expect_state("ready_while_empty", 0, 0, 0, 13, 0, 1);

        // Toggle every cycle with ready high: one event in flight at all times.
        for (int i = 0; i < 4; i++) begin
            lvl0 = ~lvl0;
            tick();
            expect_state($sformatf("back_to_back_%0d", i), 0, 1, 1, 14 + i, 0, (i % 2 == 0) ? 0 : 1);
        end

        rst = 1'b1; lvl0 = 1'b0;
        #2 rst = 1'b0;
        rdy0 = 1'b1;
        for (int i = 0; i < 256; i++) begin
            lvl0 = ~lvl0;
            tick();
        end
        expect_state("total_wrap", 0, 1, 1, 0, 0, 0);
        tick();
        expect_state("wrap_drain", 0, 0, 0, 0, 0, 0);

        rdy0 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            lvl0 = ~lvl0;
            tick();
        end
        expect_state("three_pending", 0, 3, 1, 3, 0, 1);

        // Reset between edges, level_in left opposite to INIT_LEVEL.
        #2 rst = 1'b1;
        #1;
        check_reset_outputs("async_reset_mid");
        rst = 1'b0;
        tick();
        expect_state("event_after_release", 0, 1, 1, 1, 0, 1);

        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/toggle_event_decoder.md
# toggle_event_decoder

Receiving end of the toggle-encoded event interface: recovers discrete events from a level signal that flips once per event, as driven by a `toggle` block. Each transition of `level_in` becomes one event. Events are queued in a saturating pending counter and handed out one at a time on a valid/ready handshake. The block also keeps a wrapping total-event count and a sticky overflow flag.

## Interface
- `SYNC_STAGES`, default 2: synchronizer flops on `level_in`, legal range 0..3; 0 means `level_in` is used directly, for a same-clock source.
- `INIT_LEVEL`, default 1'b0: reset value of the synchronizer flops and of the level history register.
- `PEND_WIDTH`, default 3: width of the pending-event counter.
- `CNT_WIDTH`, default 8: width of the total-event counter.
- `clk` input 1: sole clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `level_in` input 1: toggle-encoded event line; each transition is one event.
- `evt_valid` output 1: at least one event is pending.
- `evt_ready` input 1: consumer accepts one event when `evt_valid` is high.
- `pending` output PEND_WIDTH: number of events queued.
- `total_events` output CNT_WIDTH: count of all detected transitions, modulo 2^CNT_WIDTH.
- `overflow` output 1: sticky; an event was dropped because `pending` was saturated.
- `clear_ovf` input 1: synchronous clear of `overflow`.
- `level` output 1: last sampled level, i.e. the history register.

## Operation
- `level_q` is `level_in` delayed through SYNC_STAGES flops; with SYNC_STAGES=0 it is `level_in` itself.
- `prev` register: loads `level_q` every cycle.
- Edge detect: `edge = level_q ^ prev` (combinational).
  - Only one event per cycle is possible.
  - A pulse of `level_in` shorter than one cycle is not guaranteed to be detected.
- `pop = evt_valid & evt_ready`.
- Pending update, where FULL = 2^PEND_WIDTH-1:
  - edge and no pop: +1 if `pending` < FULL. If `pending` == FULL, the event is dropped, `pending` stays at FULL and `overflow` is set.
  - pop and no edge: -1.
  - edge and pop together: no change, and no overflow even when `pending` is at FULL.
  - neither: hold.
- `evt_valid = (pending != 0)`, driven combinationally from the register.
  - `evt_ready` while `evt_valid` is low has no effect; `pending` never underflows.
- `total_events`: +1 on every edge, including dropped events; wraps from all-ones to 0.
- `overflow` clearing:
  - `clear_ovf` clears it on the next edge.
  - If `clear_ovf` and a drop occur in the same cycle, the set wins and `overflow` ends at 1.
- States are implicit in `pending`:
  - 0: IDLE, `evt_valid` = 0.
  - 1..FULL-1: QUEUED.
  - FULL: SATURATED.

## Timing
- Reset values while `rst` is high, applied asynchronously:
  - sync flops = INIT_LEVEL, `prev` = INIT_LEVEL, `level` = INIT_LEVEL;
  - `pending` = 0, `evt_valid` = 0, `total_events` = 0, `overflow` = 0.
- Latency: with `level_in` changed and stable before edge k:
  - `prev` and `pending` update at edge k + SYNC_STAGES;
  - `evt_valid` rises immediately after that edge.
- Handshake: an event is consumed at the rising edge on which `evt_valid` and `evt_ready` are both high. `pending` shows the decrement after that edge.
- Reset mid-operation: the queued events and the counts are lost. On release, `prev` = INIT_LEVEL.
  - If `level_in` differs from INIT_LEVEL at release, one event is detected SYNC_STAGES cycles after the first post-release edge.
- Back-to-back: `level_in` toggling every cycle with `evt_ready` held high gives `evt_valid` continuously high and `pending` steady at 1.

## Test plan
- Reset and hold:
  - Stimulus: INIT_LEVEL=0, SYNC_STAGES=0, `level_in`=0, `rst` pulsed, 2 clocks.
  - Required: `evt_valid`=0, `pending`=0, `total_events`=0, `overflow`=0.
- Single event:
  - Stimulus: from the reset state, set `level_in`=1, `evt_ready`=0, then 1 clock.
  - Required: `evt_valid`=1, `pending`=1, `total_events`=1.
  - Continue: `evt_ready`=1 for 1 clock. Required: `evt_valid`=0, `pending`=0.
- Saturation:
  - Stimulus: PEND_WIDTH=3, `evt_ready`=0, `level_in` toggled every cycle for 9 clocks.
  - Required: `pending`=7, `overflow`=1, `total_events`=9.
  - Continue: pulse `clear_ovf`. Required: `overflow`=0.
- Simultaneous edge and pop at FULL:
  - Stimulus: `pending`=7, then toggle `level_in` with `evt_ready`=1 for 1 clock.
  - Required: `pending`=7, `overflow` unchanged.
- Synchronizer latency:
  - Stimulus: SYNC_STAGES=2, `level_in` 0->1.
  - Required: `evt_valid` rises exactly after the 3rd rising edge.
- Wrap and mid-operation reset:
  - Stimulus: CNT_WIDTH=8, `evt_ready`=1, 256 toggles.
  - Required: `total_events`=0.
  - Continue: assert `rst` between clock edges while `pending`=3. Required: all outputs go to reset values without waiting for a clock edge.
